// File: rtl/mdu_div_iter_pkg.sv
// Shared definitions for the iterative RV32M divider: op codes, FSM states and sign helpers.
// Op codes must stay identical to the ALU decode of the same 5-bit op field.
package mdu_div_iter_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_DIV  = 5'd20;
  localparam logic [OP_W-1:0] OP_DIVU = 5'd21;
  localparam logic [OP_W-1:0] OP_REM  = 5'd22;
  localparam logic [OP_W-1:0] OP_REMU = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ({XLEN{1'b0}} - v) : v;
  endfunction

  // Two's-complement magnitude for signed ops; unsigned ops pass straight through.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return cond_neg(v, is_signed & v[XLEN-1]);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
//
// state | meaning
// IDLE  | ready for a request; latches operands on an accepted divide op
// CALC  | 32 iterations of restoring division, counter 0..31
// DONE  | result valid, held until out_ready_i
module mdu_div_iter
  import mdu_div_iter_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [OP_W-1:0] in_op_i,
  input  logic [XLEN-1:0] in_src1_i,
  input  logic [XLEN-1:0] in_src2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o,
  input  logic            flush_i,
  output logic            busy_o
);

  div_state_e      state_q;
  logic [OP_W-1:0] op_q;
  logic            neg_q_q, neg_r_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, result_q;
  logic [4:0]      cnt_q;
  logic            out_valid_q;

  logic            req_is_div, req_signed, req_rem, req_div_zero, req_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted, trial;
  logic            qbit;
  logic [XLEN-1:0] quo_d, rem_d, q_fix, r_fix;

  always_comb begin
    req_is_div   = (in_op_i == OP_DIV) || (in_op_i == OP_DIVU) ||
                   (in_op_i == OP_REM) || (in_op_i == OP_REMU);
    req_signed   = (in_op_i == OP_DIV) || (in_op_i == OP_REM);
    req_rem      = (in_op_i == OP_REM) || (in_op_i == OP_REMU);
    a_mag        = abs_val(in_src1_i, req_signed);
    b_mag        = abs_val(in_src2_i, req_signed);
    req_div_zero = (in_src2_i == '0);
    req_ovf      = req_signed && (in_src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (in_src2_i == '1);
  end

  // The 33rd bit exists only here: a negative trial leaves the remainder untouched.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[XLEN];
    rem_d   = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], qbit};
    q_fix   = cond_neg(quo_d, neg_q_q);
    r_fix   = cond_neg(rem_d, neg_r_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && req_is_div) begin
            op_q    <= in_op_i;
            neg_q_q <= req_signed & (in_src1_i[XLEN-1] ^ in_src2_i[XLEN-1]);
            neg_r_q <= req_signed & in_src1_i[XLEN-1];
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
            if (req_div_zero) begin
              result_q    <= req_rem ? in_src1_i : '1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (req_ovf) begin
              result_q    <= req_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
`ifdef DIV_EARLY_OUT_EN
            end else if (a_mag < b_mag) begin
              result_q    <= req_rem ? in_src1_i : '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
`endif
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q    <= ((op_q == OP_REM) || (op_q == OP_REMU)) ? r_fix : q_fix;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign out_valid_o  = out_valid_q;
  assign out_result_o = result_q;

endmodule

// File: tb/tb_mdu_div_iter.sv
// Self-checking bench for mdu_div_iter: directed vectors, random ops against an arithmetic model,
// result hold, flush, reset and back-to-back handling. Honours DIV_EARLY_OUT_EN for latency.
`timescale 1ns/1ps
module tb_mdu_div_iter;
  import mdu_div_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        flush = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_div_iter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_src1_i    (in_src1),
    .in_src2_i    (in_src2),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .flush_i      (flush),
    .busy_o       (busy)
  );

  // RISC-V M semantics straight from signed/unsigned arithmetic.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) return (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : a;
    if (op == OP_DIVU) return a / b;
    if (op == OP_REMU) return a % b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == OP_DIV) ? a : 32'd0;
    if (op == OP_DIV) return 32'(sa / sb);
    return 32'(sa % sb);
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sgn;
`ifdef DIV_EARLY_OUT_EN
    longint ma, mb;
`endif
    sgn = (op == OP_DIV || op == OP_REM);
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    ma = sgn ? longint'($signed(a)) : longint'(a);
    mb = sgn ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Called #1 after a posedge; returns #1 after a posedge with the unit back in IDLE.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] exp;
    int exp_lat, lat;
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    in_op = op; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL %s timeout: out_valid=%b after %0d cycles", name, out_valid, lat);
      flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
      return;
    end
    n_cmp++;
    if (out_result !== exp) begin
      n_err++;
      $display("FAIL %s result op=%0d a=%h b=%h: got %h want %h", name, op, a, b, out_result, exp);
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s release: out_valid=%b busy=%b want 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b res=%h want 1 0 0 0",
               in_ready, out_valid, busy, out_result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_op(OP_REMU, 32'd100, 32'd7, "remu_100_7");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    run_op(OP_DIV,  32'd5, 32'd0, "div_5_0");
    run_op(OP_REM,  32'd5, 32'd0, "rem_5_0");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd0, "divu_max_0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(OP_DIVU, 32'd3, 32'd10, "divu_small");
    run_op(OP_REM,  32'hFFFF_FFFD, 32'd10, "rem_small_neg");
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 5'(20 + $urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(51, 1000)); end
        3: b = 32'($urandom_range(1, 15));
        4: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  task automatic test_ignored_op();
    in_op = 5'd5; in_src1 = 32'd9; in_src2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL ignored_op: busy=%b rdy=%b vld=%b want 0 1 0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_hold();
    int lat;
    in_op = OP_DIVU; in_src1 = 32'd100; in_src2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    in_op = OP_DIVU; in_src1 = 32'd9; in_src2 = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== 32'd14 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold cycle %0d: vld=%b res=%h rdy=%b want 1 0000000e 0",
                 i, out_valid, out_result, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL hold_release: vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_flush();
    bit rose;
    in_op = OP_DIVU; in_src1 = 32'd100; in_src2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_calc: busy=%b rdy=%b vld=%b want 0 1 0", busy, in_ready, out_valid);
    end
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) rose = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (rose) begin
      n_err++; $display("FAIL flush_no_result: out_valid rose=%b want 0", rose);
    end
    run_op(OP_DIVU, 32'd9, 32'd3, "after_flush");

    in_op = OP_DIVU; in_src1 = 32'd50; in_src2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL flush_with_req: busy=%b want 0", busy);
    end

    in_op = OP_DIV; in_src1 = 32'd5; in_src2 = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL flush_done: vld=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_calc();
    in_op = OP_DIVU; in_src1 = 32'd1000; in_src2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_calc: busy=%b rdy=%b vld=%b res=%h want 0 1 0 0",
               busy, in_ready, out_valid, out_result);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(OP_REMU, 32'd1000, 32'd3, "after_reset");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    run_op(OP_DIVU, 32'd9, 32'd3, "b2b_0");
    out_ready = 1'b1;
    run_op(OP_REMU, 32'd10, 32'd4, "b2b_1");
    out_ready = 1'b1;
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd16, "b2b_2");
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_op();
    test_hold();
    test_flush();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mdu_div_iter.md
Name: mdu_div_iter

Overview:
- Multi-cycle RV32M divide unit. Executes DIV, DIVU, REM and REMU for the execute stage.
- Replaces the combinational divide and remainder paths in the ALU.
- Takes its operation code from the same 5-bit ALU op field the ALU decodes.
- Talks to the execute stage through a valid/ready request and a valid/ready response, with a flush input for pipeline squash.

Parameters:
- XLEN, 32, operand and result width.
- OP_W, 5, width of the op field.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- in_op  input  OP_W  20=DIV, 21=DIVU, 22=REM, 23=REMU
- in_src1  input  XLEN  dividend
- in_src2  input  XLEN  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  XLEN  quotient or remainder, selected by the latched op
- flush  input  1  cancel any in-flight operation
- busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: IDLE, in_ready=1, out_valid=0, out_result=0, busy=0. All internal registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid&in_ready) with in_op outside 20..23 is accepted and ignored; the unit stays in IDLE.
  - Otherwise latch the op, the sign flags and the absolute operand values. Signed ops take the two's-complement magnitude; unsigned ops pass the operands through.
  - Divisor==0 goes straight to DONE with q=all-ones and r=dividend.
  - Signed 0x80000000 / 0xFFFFFFFF goes straight to DONE with q=0x80000000 and r=0.
  - Any other request goes to CALC with the counter at 0.
- CALC:
  - Restoring radix-2 division, one quotient bit per cycle, on a 33-bit partial remainder.
  - The counter runs 0..31. On count 31, move to DONE.
  - On the DONE transition, apply sign correction: negate q if the operand signs differ (DIV); r takes the dividend's sign (REM).
- DONE:
  - out_valid=1. out_result holds stable while out_ready=0.
  - On out_ready, move to IDLE.
  - in_ready=0; back-to-back acceptance in the same cycle as out_ready is not supported.
- Latency, accept edge to first out_valid cycle:
  - Normal operation: 33 cycles.
  - Divide-by-zero and overflow: 1 cycle.
- flush:
  - Highest priority. In any state, the next state is IDLE and out_valid drops the next cycle.
  - A request presented in the same cycle as flush is not accepted (in_ready is still 1, but the handshake is discarded).
- rst_n asserted mid-CALC: immediate return to the reset state; no result is emitted.
- Arithmetic: all internal magnitudes are unsigned 32-bit; the 33rd bit exists only in the trial subtract.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: in IDLE, if |dividend| < |divisor| (unsigned magnitude compare), go straight to DONE with q=0 and r=the original dividend. Latency is 1 cycle.
- When undefined: these cases take the normal 33-cycle path. Results are identical either way; only latency differs.

Decomposition:
- Shared package holds:
  - op constants OP_DIV=5'd20, OP_DIVU=5'd21, OP_REM=5'd22, OP_REMU=5'd23, kept identical to the ALU's decode;
  - the state encoding IDLE/CALC/DONE;
  - XLEN.
- No sub-module. The sign pre/post fix-up is a small function in the package (abs and conditional negate), shared with any future multiplier.

Test Plan:
- DIVU 100/7 -> 14 after 33 cycles; REMU 100/7 -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF after 1 cycle; REM 5/0 -> 5; DIVU 0xFFFFFFFF/0 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; both after 1 cycle.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_result stay stable and in_ready stays 0. Release -> IDLE next cycle.
- Assert flush at CALC count 10 -> out_valid never rises, IDLE next cycle. A new DIVU 9/3 then returns 3.
